// File: rtl/i2s_tdm_rx.sv
// I2S/TDM serial-audio receiver: deserialises NUM_SLOTS slots per ws frame into 32-bit words
// and queues them with channel tags in a fall-through FIFO. Optional macro: I2S_RX_SIGN_EXT_EN.
module i2s_tdm_rx #(
    parameter int unsigned NUM_SLOTS  = 2,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned SAMPLE_W   = 24,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned CH_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             sck,
    input  logic             rst,
    input  logic             en,
    input  logic             ws,
    input  logic             sd,
    input  logic             out_ready,
    input  logic             flag_clr,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic [CH_W-1:0]  out_chan,
    output logic [LVL_W-1:0] fifo_level,
    output logic             ovf,
    output logic             frame_err
);

    localparam int unsigned FRAME_BITS = NUM_SLOTS * SLOT_W;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
    localparam int unsigned POS_W      = $clog2(SLOT_W);
    localparam int unsigned AW         = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t              state;
    logic                ws_q;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-2:0] shreg;

    logic                fs_c;
    logic                last_c;
    logic                run_c;
    logic                cap_c;
    logic                err_c;
    logic                shift_c;
    logic                push_c;
    logic [POS_W-1:0]    pos_c;
    logic [CH_W-1:0]     slot_c;
    logic [SAMPLE_W-1:0] sample_c;
    logic [31:0]         word_c;

    // Frame position decode; a bit is captured only when fs and the last position coincide or neither occurs.
    always_comb begin
        fs_c     = ws_q & ~ws;
        last_c   = (bit_cnt == CNT_W'(FRAME_BITS - 1));
        pos_c    = bit_cnt[POS_W-1:0];
        slot_c   = CH_W'(bit_cnt[CNT_W-1:POS_W]);
        run_c    = (state == RUN) & en;
        cap_c    = run_c & (fs_c == last_c);
        err_c    = run_c & (fs_c != last_c);
        shift_c  = cap_c & (32'(pos_c) < SAMPLE_W);
        push_c   = cap_c & (32'(pos_c) == SAMPLE_W - 1);
        sample_c = {shreg, sd};
`ifdef I2S_RX_SIGN_EXT_EN
        word_c   = 32'($signed(sample_c));
`else
        word_c   = 32'(sample_c) << (32 - SAMPLE_W);
`endif
    end

    // Frame tracking FSM; a partial word is dropped simply by never reaching its push position.
    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ws_q      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            ws_q <= ws;
            if (shift_c) begin
                shreg <= sample_c[SAMPLE_W-2:0];
            end
            if (err_c) begin
                frame_err <= 1'b1;
            end else if (flag_clr) begin
                frame_err <= 1'b0;
            end
            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: begin
                        if (fs_c) begin
                            state   <= RUN;
                            bit_cnt <= '0;
                        end
                    end
                    RUN: begin
                        if (fs_c) begin
                            bit_cnt <= '0;
                        end else if (last_c) begin
                            state <= SYNC;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic [31:0]     mem_data [FIFO_DEPTH];
    logic [CH_W-1:0] mem_chan [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    logic             pop_c;
    logic             full_c;
    logic             accept_c;
    logic             drop_c;
    logic [LVL_W-1:0] level_nxt_c;
    logic [AW-1:0]    rd_nxt_c;
    logic [31:0]      head_data_c;
    logic [CH_W-1:0]  head_chan_c;

    // FIFO bookkeeping; the head register is preloaded so a word into an empty FIFO falls through.
    always_comb begin
        pop_c       = out_valid & out_ready;
        full_c      = (fifo_level == LVL_W'(FIFO_DEPTH));
        accept_c    = push_c & (~full_c | pop_c);
        drop_c      = push_c & full_c & ~pop_c;
        level_nxt_c = fifo_level + LVL_W'(accept_c) - LVL_W'(pop_c);
        rd_nxt_c    = rd_ptr + AW'(pop_c);
        head_data_c = '0;
        head_chan_c = '0;
        if (level_nxt_c != '0) begin
            if (accept_c && (rd_nxt_c == wr_ptr)) begin
                head_data_c = word_c;
                head_chan_c = slot_c;
            end else begin
                head_data_c = mem_data[rd_nxt_c];
                head_chan_c = mem_chan[rd_nxt_c];
            end
        end
    end

    always_ff @(posedge sck) begin
        if (accept_c) begin
            mem_data[wr_ptr] <= word_c;
            mem_chan[wr_ptr] <= slot_c;
        end
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            ovf        <= 1'b0;
        end else begin
            if (accept_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_nxt_c;
            fifo_level <= level_nxt_c;
            out_valid  <= (level_nxt_c != '0);
            out_data   <= head_data_c;
            out_chan   <= head_chan_c;
            if (drop_c) begin
                ovf <= 1'b1;
            end else if (flag_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Randomised bench for i2s_tdm_rx: frames are generated bit-serially and expected words
// are derived per frame from slot contents, frame length and enable/ready timing.
module tb_i2s_tdm_rx;

    logic        sck = 1'b0;
    logic        rst;
    logic        en;
    logic        ws;
    logic        sd;
    logic        out_ready;
    logic        flag_clr;
    logic        out_valid;
    logic [31:0] out_data;
    logic [0:0]  out_chan;
    logic [2:0]  fifo_level;
    logic        ovf;
    logic        frame_err;

    i2s_tdm_rx dut (
        .sck        (sck),
        .rst        (rst),
        .en         (en),
        .ws         (ws),
        .sd         (sd),
        .out_ready  (out_ready),
        .flag_clr   (flag_clr),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .fifo_level (fifo_level),
        .ovf        (ovf),
        .frame_err  (frame_err)
    );

    always #5 sck = ~sck;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];
    bit          last_bit = 1'b0;

    // Record every word the consumer accepts, in order.
    always @(negedge sck) begin
        #2;
        if (!rst && out_valid && out_ready) got_q.push_back({out_chan, out_data});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] word(input logic [23:0] s, input logic ch);
`ifdef I2S_RX_SIGN_EXT_EN
        return {ch, {8{s[23]}}, s};
`else
        return {ch, s, 8'h00};
`endif
    endfunction

    // One ws frame of p sck cycles; L/R occupy the first 24 bits of each slot, the rest is junk.
    // Edge i samples frame bit i-1; edge 0 (ws fall) carries the previous frame's last bit.
    task automatic send_frame(input int p, input logic [23:0] l, input logic [23:0] r,
                              input int at1, input int k1, input int at2, input int k2);
        bit fb[128];
        bit rel;
        for (int j = 0; j < 128; j++) fb[j] = 1'($urandom);
        for (int j = 0; j < 24; j++) begin
            fb[j]      = l[23-j];
            fb[32 + j] = r[23-j];
        end
        rel = 1'b0;
        for (int i = 0; i < p; i++) begin
            @(negedge sck);
            ws = (i < p / 2) ? 1'b0 : 1'b1;
            sd = (i == 0) ? last_bit : fb[i-1];
            if (rel) begin
                out_ready = 1'b0;
                rel       = 1'b0;
            end
            if (i == at1 || i == at2) begin
                int k;
                k = (i == at1) ? k1 : k2;
                case (k)
                    1: en = 1'b0;
                    2: en = 1'b1;
                    3: begin out_ready = 1'b1; rel = 1'b1; end
                    default: ;
                endcase
            end
        end
        last_bit = fb[p-1];
    endtask

    task automatic start_stream;
        @(negedge sck);
        en = 1'b1;
        ws = 1'b1;
        repeat (3) @(negedge sck);
    endtask

    task automatic end_stream;
        @(negedge sck);
        en = 1'b0;
        repeat (2) @(negedge sck);
    endtask

    task automatic drain;
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (fifo_level == 3'd0) break;
            @(negedge sck);
        end
        #3;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; ws = 1'b1; sd = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
        repeat (3) @(negedge sck);
        n_checks++;
        if ({out_valid, fifo_level} !== 4'd0) begin
            n_fail++; $display("FAIL reset_valid_level: got %b/%0d expected 0/0", out_valid, fifo_level);
        end
        n_checks++;
        if ({out_chan, out_data} !== 33'd0) begin
            n_fail++; $display("FAIL reset_data: got %0d/%h expected 0/0", out_chan, out_data);
        end
        n_checks++;
        if ({ovf, frame_err} !== 2'b00) begin
            n_fail++; $display("FAIL reset_flags: got %b%b expected 00", ovf, frame_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [23:0] l, r;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1;
        start_stream();
        send_frame(64, 24'hA5A5A5, 24'h123456, -1, 0, -1, 0);
        exp_q.push_back(word(24'hA5A5A5, 1'b0));
        exp_q.push_back(word(24'h123456, 1'b1));
        for (int f = 0; f < 3; f++) begin
            l = 24'($urandom); r = 24'($urandom);
            send_frame(64, l, r, -1, 0, -1, 0);
            exp_q.push_back(word(l, 1'b0));
            exp_q.push_back(word(r, 1'b1));
        end
        end_stream();
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({ovf, frame_err} !== 2'b00) begin
            n_fail++; $display("FAIL basic_flags: got %b%b expected 00", ovf, frame_err);
        end
        n_checks++;
        if ({out_valid, out_chan, out_data} !== 34'd0) begin
            n_fail++; $display("FAIL basic_empty_head: got %b/%0d/%h expected 0/0/0", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_overflow;
        logic [23:0] l, r;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        start_stream();
        for (int f = 0; f < 3; f++) begin
            l = 24'($urandom); r = 24'($urandom);
            send_frame(64, l, r, -1, 0, -1, 0);
            if (f < 2) begin
                exp_q.push_back(word(l, 1'b0));
                exp_q.push_back(word(r, 1'b1));
            end
            if (f == 1) begin
                n_checks++;
                if ({fifo_level, ovf} !== {3'd4, 1'b0}) begin
                    n_fail++; $display("FAIL ovf_after4: got level %0d ovf %b expected 4/0", fifo_level, ovf);
                end
            end
        end
        n_checks++;
        if ({fifo_level, ovf} !== {3'd4, 1'b1}) begin
            n_fail++; $display("FAIL ovf_after6: got level %0d ovf %b expected 4/1", fifo_level, ovf);
        end
        end_stream();
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL ovf_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ovf);
        end
        @(negedge sck); flag_clr = 1'b1;
        @(negedge sck); flag_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b expected 0", ovf);
        end
    endtask

    task automatic test_frame_err;
        logic [23:0] l [4];
        logic [23:0] r [4];
        exp_q.delete(); got_q.delete();
        for (int f = 0; f < 4; f++) begin
            l[f] = 24'($urandom); r[f] = 24'($urandom);
        end
        out_ready = 1'b1;
        start_stream();
        send_frame(64, l[0], r[0], -1, 0, -1, 0);
        exp_q.push_back(word(l[0], 1'b0)); exp_q.push_back(word(r[0], 1'b1));
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL ferr_good: got %b expected 0", frame_err);
        end
        // 50-cycle frame: right slot never completes.
        send_frame(50, l[1], r[1], -1, 0, -1, 0);
        exp_q.push_back(word(l[1], 1'b0));
        // 70-cycle frame: both words complete before the length check fires.
        send_frame(70, l[2], r[2], -1, 0, -1, 0);
        exp_q.push_back(word(l[2], 1'b0)); exp_q.push_back(word(r[2], 1'b1));
        send_frame(64, l[3], r[3], -1, 0, -1, 0);
        exp_q.push_back(word(l[3], 1'b0)); exp_q.push_back(word(r[3], 1'b1));
        end_stream();
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL ferr_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL ferr_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({frame_err, ovf} !== 2'b10) begin
            n_fail++; $display("FAIL ferr_set: got ferr %b ovf %b expected 1/0", frame_err, ovf);
        end
        @(negedge sck); flag_clr = 1'b1;
        @(negedge sck); flag_clr = 1'b0;
        n_checks++;
        if (frame_err !== 1'b0) begin
            n_fail++; $display("FAIL ferr_clear: got %b expected 0", frame_err);
        end
    endtask

    task automatic test_enable;
        logic [23:0] l [4];
        logic [23:0] r [4];
        exp_q.delete(); got_q.delete();
        for (int f = 0; f < 4; f++) begin
            l[f] = 24'($urandom); r[f] = 24'($urandom);
        end
        out_ready = 1'b0;
        start_stream();
        send_frame(64, l[0], r[0], -1, 0, -1, 0);
        exp_q.push_back(word(l[0], 1'b0)); exp_q.push_back(word(r[0], 1'b1));
        send_frame(64, l[1], r[1], 11, 1, -1, 0);
        n_checks++;
        if (fifo_level !== 3'd2) begin
            n_fail++; $display("FAIL en_off_level: got %0d expected 2", fifo_level);
        end
        send_frame(64, l[2], r[2], 20, 2, -1, 0);
        send_frame(64, l[3], r[3], -1, 0, -1, 0);
        exp_q.push_back(word(l[3], 1'b0)); exp_q.push_back(word(r[3], 1'b1));
        n_checks++;
        if (fifo_level !== 3'd4) begin
            n_fail++; $display("FAIL en_resume_level: got %0d expected 4", fifo_level);
        end
        end_stream();
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL en_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL en_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({frame_err, ovf} !== 2'b00) begin
            n_fail++; $display("FAIL en_flags: got %b%b expected 00", frame_err, ovf);
        end
    endtask

    task automatic test_full_push_pop;
        logic [23:0] l [3];
        logic [23:0] r [3];
        exp_q.delete(); got_q.delete();
        for (int f = 0; f < 3; f++) begin
            l[f] = 24'($urandom); r[f] = 24'($urandom);
        end
        out_ready = 1'b0;
        start_stream();
        for (int f = 0; f < 2; f++) begin
            send_frame(64, l[f], r[f], -1, 0, -1, 0);
            exp_q.push_back(word(l[f], 1'b0)); exp_q.push_back(word(r[f], 1'b1));
        end
        // Ready pulses on the very edge that pushes L3 into the full FIFO; capture stops before R3.
        send_frame(64, l[2], r[2], 24, 3, 40, 1);
        exp_q.push_back(word(l[2], 1'b0));
        n_checks++;
        if ({fifo_level, ovf} !== {3'd4, 1'b0}) begin
            n_fail++; $display("FAIL full_pp: got level %0d ovf %b expected 4/0", fifo_level, ovf);
        end
        end_stream();
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL full_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL full_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] l, r;
        exp_q.delete(); got_q.delete();
        out_ready = 1'b0;
        start_stream();
        send_frame(64, 24'($urandom), 24'($urandom), -1, 0, -1, 0);
        send_frame(50, 24'($urandom), 24'($urandom), -1, 0, -1, 0);
        for (int i = 0; i < 15; i++) begin
            @(negedge sck);
            ws = 1'b0;
            sd = 1'($urandom);
        end
        n_checks++;
        if ({fifo_level, frame_err} !== {3'd3, 1'b1}) begin
            n_fail++; $display("FAIL rstmid_pre: got level %0d ferr %b expected 3/1", fifo_level, frame_err);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, fifo_level, ovf, frame_err} !== 6'd0) begin
            n_fail++; $display("FAIL rstmid_status: got v%b lvl%0d ovf%b ferr%b expected all 0",
                               out_valid, fifo_level, ovf, frame_err);
        end
        n_checks++;
        if ({out_chan, out_data} !== 33'd0) begin
            n_fail++; $display("FAIL rstmid_data: got %0d/%h expected 0/0", out_chan, out_data);
        end
        @(negedge sck);
        rst = 1'b0;
        en  = 1'b0;
        ws  = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        start_stream();
        l = 24'($urandom); r = 24'($urandom);
        send_frame(64, l, r, -1, 0, -1, 0);
        exp_q.push_back(word(l, 1'b0)); exp_q.push_back(word(r, 1'b1));
        end_stream();
        drain();
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rstmid_count: got %0d words expected %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rstmid_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_frame_err();
        test_enable();
        test_full_push_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
